// File: rtl/packet_transmitter.sv
// packet_transmitter: drains buffered frames from a FWFT frame FIFO and applies
// the per-frame permit/deny decision. Permitted frames go out on the AXI-Stream
// TX port followed by an inter-frame gap; denied frames are popped and discarded.
// Wrapping counters track transmitted and dropped frames.
module packet_transmitter #(
  parameter int C_m_axis_txd_TDATA_WIDTH = 32,
  parameter int IFG_CYCLES               = 3,
  parameter int CNT_WIDTH                = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [C_m_axis_txd_TDATA_WIDTH-1:0] i_buf_rd_data,
  input  logic                                i_buf_rd_last,
  input  logic                                i_buf_empty,
  output logic                                o_buf_rd_en,
  input  logic                                i_decision_valid,
  input  logic                                i_decision_permit,
  output logic                                o_decision_ready,
  output logic [C_m_axis_txd_TDATA_WIDTH-1:0] o_txd_tdata,
  output logic                                o_txd_tvalid,
  output logic                                o_txd_tlast,
  input  logic                                i_txd_tready,
  output logic [CNT_WIDTH-1:0]                o_tx_frame_cnt,
  output logic [CNT_WIDTH-1:0]                o_drop_frame_cnt,
  output logic                                o_underrun
);

  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_LAST,
    DROP,
    GAP
  } state_t;

  state_t                                r_state;
  state_t                                w_next_state;
  logic [C_m_axis_txd_TDATA_WIDTH-1:0]   r_tdata;
  logic                                  r_tvalid;
  logic                                  r_tlast;
  logic [CNT_WIDTH-1:0]                  r_tx_cnt;
  logic [CNT_WIDTH-1:0]                  r_drop_cnt;
  logic [GW-1:0]                         r_gap_cnt;
  logic                                  w_slot;
  logic                                  w_load;
  logic                                  w_tx_last_hs;
  logic                                  w_drop_last;
  logic                                  w_gap_done;

  // Output register is free when empty or being handed off this cycle
  assign w_slot       = !r_tvalid || i_txd_tready;
  assign w_load       = (r_state == SEND) && o_buf_rd_en;
  assign w_tx_last_hs = r_tvalid && i_txd_tready && r_tlast;
  assign w_drop_last  = (r_state == DROP) && o_buf_rd_en && i_buf_rd_last;
  assign w_gap_done   = (r_gap_cnt == GAP_LAST);

  assign o_txd_tdata      = r_tdata;
  assign o_txd_tvalid     = r_tvalid;
  assign o_txd_tlast      = r_tlast;
  assign o_tx_frame_cnt   = r_tx_cnt;
  assign o_drop_frame_cnt = r_drop_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_decision_valid && o_decision_ready) begin
          w_next_state = i_decision_permit ? SEND : DROP;
        end
      end
      SEND: begin
        if (w_load && i_buf_rd_last) begin
          w_next_state = WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (w_tx_last_hs) begin
          w_next_state = (IFG_CYCLES == 0) ? IDLE : GAP;
        end
      end
      DROP: begin
        if (w_drop_last) begin
          w_next_state = IDLE;
        end
      end
      GAP: begin
        if (w_gap_done) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FIFO pop, decision handshake and underrun flag, all held low during reset
  always_comb begin
    o_decision_ready = 1'b0;
    o_buf_rd_en      = 1'b0;
    o_underrun       = 1'b0;
    if (rst) begin
      case (r_state)
        IDLE: o_decision_ready = !i_buf_empty;
        SEND: begin
          o_buf_rd_en = w_slot && !i_buf_empty;
          o_underrun  = w_slot && i_buf_empty;
        end
        DROP: o_buf_rd_en = !i_buf_empty;
        default: ;
      endcase
    end
  end

  // TX output register: load on a free slot, clear after a handshake with no reload
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_load) begin
      r_tdata  <= i_buf_rd_data;
      r_tlast  <= i_buf_rd_last;
      r_tvalid <= 1'b1;
    end else if (r_tvalid && i_txd_tready) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

  // Frame counters and inter-frame gap timer
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_cnt   <= '0;
      r_drop_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (w_tx_last_hs) begin
        r_tx_cnt <= r_tx_cnt + CNT_WIDTH'(1);
      end
      if (w_drop_last) begin
        r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
      if ((r_state == GAP) && !w_gap_done) begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_packet_transmitter.sv
// Testbench for packet_transmitter: FWFT FIFO and decision models driven from
// the stimulus process, with a separate monitor scoring TX beats against a queue.
module tb_packet_transmitter;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] i_buf_rd_data;
  logic          i_buf_rd_last;
  logic          i_buf_empty;
  logic          o_buf_rd_en;
  logic          i_decision_valid;
  logic          i_decision_permit;
  logic          o_decision_ready;
  logic [DW-1:0] o_txd_tdata;
  logic          o_txd_tvalid;
  logic          o_txd_tlast;
  logic          i_txd_tready;
  logic [CW-1:0] o_tx_frame_cnt;
  logic [CW-1:0] o_drop_frame_cnt;
  logic          o_underrun;

  packet_transmitter #(
    .C_m_axis_txd_TDATA_WIDTH(DW),
    .IFG_CYCLES              (3),
    .CNT_WIDTH               (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_buf_rd_data    (i_buf_rd_data),
    .i_buf_rd_last    (i_buf_rd_last),
    .i_buf_empty      (i_buf_empty),
    .o_buf_rd_en      (o_buf_rd_en),
    .i_decision_valid (i_decision_valid),
    .i_decision_permit(i_decision_permit),
    .o_decision_ready (o_decision_ready),
    .o_txd_tdata      (o_txd_tdata),
    .o_txd_tvalid     (o_txd_tvalid),
    .o_txd_tlast      (o_txd_tlast),
    .i_txd_tready     (i_txd_tready),
    .o_tx_frame_cnt   (o_tx_frame_cnt),
    .o_drop_frame_cnt (o_drop_frame_cnt),
    .o_underrun       (o_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          und_cnt = 0;
  int          acc_cyc = 0;
  bit          got_acc = 0;
  bit          stall = 0;
  logic [32:0] fifo[$];
  logic        dq[$];
  logic [32:0] exp_q[$];
  int          hs_q[$];
  int          pop_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, want);
    end
  endtask

  task automatic drive();
    i_buf_empty = stall || (fifo.size() == 0);
    if (fifo.size() != 0) {i_buf_rd_last, i_buf_rd_data} = fifo[0];
    else {i_buf_rd_last, i_buf_rd_data} = '0;
    i_decision_valid  = (dq.size() != 0);
    i_decision_permit = (dq.size() != 0) ? dq[0] : 1'b0;
  endtask

  task automatic push_frame(input bit permit, input int n, input logic [31:0] base, input bit with_dec);
    logic [32:0] w;
    for (int i = 0; i < n; i++) begin
      w = {(i == n - 1), base + 32'(i)};
      fifo.push_back(w);
      if (permit) exp_q.push_back(w);
    end
    if (with_dec) dq.push_back(permit);
    drive();
  endtask

  // One clock: sample handshakes before the edge, apply them to the models after it
  task automatic tick();
    bit          pf;
    bit          pd;
    logic [32:0] tw;
    logic        td;
    @(negedge clk);
    pf = o_buf_rd_en;
    pd = i_decision_valid && o_decision_ready;
    @(posedge clk);
    #1;
    got_acc = 0;
    if (pf && fifo.size() != 0) begin
      pop_q.push_back(cyc);
      tw = fifo.pop_front();
    end
    if (pd && dq.size() != 0) begin
      acc_cyc = cyc;
      got_acc = 1;
      td = dq.pop_front();
    end
    cyc++;
    drive();
    #1;
  endtask

  task automatic wait_accept(input string name, output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (got_acc) begin
        n = acc_cyc;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no accept expected accept within 40 cycles", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 300;
    while ((fifo.size() != 0 || dq.size() != 0 || exp_q.size() != 0 || o_txd_tvalid) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got pending traffic expected drained within 300 cycles", name);
    end
    repeat (5) tick();
  endtask

  // Monitor: score every TX handshake and check stability under backpressure
  initial begin
    bit          hold;
    logic [32:0] held;
    logic [32:0] e;
    hold = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 0;
      end else begin
        if (o_underrun) und_cnt++;
        if (hold) begin
          checks++;
          if (!o_txd_tvalid || {o_txd_tlast, o_txd_tdata} !== held) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b word=0x%0h expected valid=1 word=0x%0h",
                     o_txd_tvalid, {o_txd_tlast, o_txd_tdata}, held);
          end
        end
        if (o_txd_tvalid && i_txd_tready) begin
          checks++;
          hs_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat: got unexpected beat 0x%0h expected no beat", {o_txd_tlast, o_txd_tdata});
          end else begin
            e = exp_q.pop_front();
            if ({o_txd_tlast, o_txd_tdata} !== e) begin
              errors++;
              $display("FAIL beat: got 0x%0h expected 0x%0h", {o_txd_tlast, o_txd_tdata}, e);
            end
          end
        end
        hold = o_txd_tvalid && !i_txd_tready;
        held = {o_txd_tlast, o_txd_tdata};
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2, n3, n4, n5;
    int e3[4];
    int e4[4];
    rst = 1'b0;
    i_txd_tready = 1'b1;
    drive();

    // Reset state with traffic already queued
    push_frame(1, 4, 32'hA000_0000, 1);
    push_frame(0, 5, 32'hB000_0000, 1);
    repeat (3) tick();
    check("rst_tvalid", 32'(o_txd_tvalid), 0);
    check("rst_tlast", 32'(o_txd_tlast), 0);
    check("rst_tdata", o_txd_tdata, 0);
    check("rst_tx_cnt", 32'(o_tx_frame_cnt), 0);
    check("rst_drop_cnt", 32'(o_drop_frame_cnt), 0);
    check("rst_ready", 32'(o_decision_ready), 0);
    check("rst_rd_en", 32'(o_buf_rd_en), 0);

    // 1: permitted 4-word frame, then gap before the next decision
    rst = 1'b1;
    #1;
    wait_accept("t1_accept", n1);
    wait_accept("t2_accept", n2);
    check("t1_next_accept", 32'(n2), 32'(n1 + 9));
    check("t1_beats", 32'(hs_q.size()), 4);
    for (int i = 0; i < 4 && i < hs_q.size(); i++) check("t1_beat_cyc", 32'(hs_q[i]), 32'(n1 + 2 + i));
    check("t1_tx_cnt", 32'(o_tx_frame_cnt), 1);

    // 2: denied 5-word frame
    hs_q.delete();
    pop_q.delete();
    push_frame(1, 4, 32'hC000_0000, 1);
    wait_accept("t3_accept", n3);
    check("t2_next_accept", 32'(n3), 32'(n2 + 6));
    check("t2_pops", 32'(pop_q.size()), 5);
    for (int i = 0; i < 5 && i < pop_q.size(); i++) check("t2_pop_cyc", 32'(pop_q[i]), 32'(n2 + 1 + i));
    check("t2_no_beats", 32'(hs_q.size()), 0);
    check("t2_drop_cnt", 32'(o_drop_frame_cnt), 1);

    // 3: backpressure on beat 2 for 3 cycles
    hs_q.delete();
    tick();
    tick();
    i_txd_tready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("t3_hold_rd_en", 32'(o_buf_rd_en), 0);
      check("t3_hold_tdata", o_txd_tdata, 32'hC000_0001);
      tick();
    end
    i_txd_tready = 1'b1;
    #1;
    wait_drain("t3_drain");
    e3 = '{n3 + 2, n3 + 6, n3 + 7, n3 + 8};
    check("t3_beats", 32'(hs_q.size()), 4);
    for (int i = 0; i < 4 && i < hs_q.size(); i++) check("t3_beat_cyc", 32'(hs_q[i]), 32'(e3[i]));
    check("t3_tx_cnt", 32'(o_tx_frame_cnt), 2);

    // 4: FIFO starved for 4 cycles after word 2
    hs_q.delete();
    und_cnt = 0;
    push_frame(1, 4, 32'hD000_0000, 1);
    wait_accept("t4_accept", n4);
    tick();
    tick();
    stall = 1;
    drive();
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) check("t4_starved_tvalid", 32'(o_txd_tvalid), 0);
      check("t4_underrun", 32'(o_underrun), 1);
      tick();
    end
    stall = 0;
    drive();
    #1;
    wait_drain("t4_drain");
    e4 = '{n4 + 2, n4 + 3, n4 + 8, n4 + 9};
    check("t4_beats", 32'(hs_q.size()), 4);
    for (int i = 0; i < 4 && i < hs_q.size(); i++) check("t4_beat_cyc", 32'(hs_q[i]), 32'(e4[i]));
    check("t4_underrun_cnt", 32'(und_cnt), 4);
    check("t4_tx_cnt", 32'(o_tx_frame_cnt), 3);

    // 5: reset during beat 3 of 6
    hs_q.delete();
    push_frame(1, 6, 32'hE000_0000, 1);
    wait_accept("t5_accept", n5);
    tick();
    tick();
    tick();
    check("t5_beat3_tdata", o_txd_tdata, 32'hE000_0002);
    rst = 1'b0;
    #1;
    tick();
    check("t5_tvalid", 32'(o_txd_tvalid), 0);
    check("t5_tlast", 32'(o_txd_tlast), 0);
    check("t5_tx_cnt", 32'(o_tx_frame_cnt), 0);
    check("t5_drop_cnt", 32'(o_drop_frame_cnt), 1'b0);
    check("t5_rst_ready", 32'(o_decision_ready), 0);
    check("t5_beats_before_rst", 32'(hs_q.size()), 2);
    fifo.delete();
    dq.delete();
    exp_q.delete();
    push_frame(1, 1, 32'hF000_0000, 0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t5_idle_rd_en", 32'(o_buf_rd_en), 0);
      check("t5_idle_ready", 32'(o_decision_ready), 1);
      tick();
    end

    // 6: counter wrap with 2-bit counters, 4 permitted + 5 denied single-word frames
    dq.push_back(1'b1);
    for (int i = 1; i < 4; i++) push_frame(1, 1, 32'hF000_0000 + 32'(i), 1);
    for (int i = 0; i < 5; i++) push_frame(0, 1, 32'h9000_0000 + 32'(i), 1);
    wait_drain("t6_drain");
    check("t6_tx_cnt_wrap", 32'(o_tx_frame_cnt), 0);
    check("t6_drop_cnt", 32'(o_drop_frame_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
